// File: rtl/cpu_regfile_mp_if.sv
// Bus bundle for the multi-port integer register file: write ports, read ports,
// busy scoreboard and the debug req/ack channel.
interface cpu_regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                 we0_i;
    logic [AW-1:0]        waddr0_i;
    logic [XLEN-1:0]      wdata0_i;
    logic                 we1_i;
    logic [AW-1:0]        waddr1_i;
    logic [XLEN-1:0]      wdata1_i;
    logic [NRD*AW-1:0]    raddr_i;
    logic [NRD*XLEN-1:0]  rdata_o;
    logic                 busy_set_i;
    logic [AW-1:0]        busy_addr_i;
    logic [NREGS-1:0]     busy_o;
    logic                 dbg_req_i;
    logic                 dbg_we_i;
    logic [AW-1:0]        dbg_addr_i;
    logic [XLEN-1:0]      dbg_wdata_i;
    logic                 dbg_ack_o;
    logic [XLEN-1:0]      dbg_rdata_o;
    logic                 ready_o;

    modport master (
        output we0_i, waddr0_i, wdata0_i, we1_i, waddr1_i, wdata1_i, raddr_i,
        output busy_set_i, busy_addr_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  rdata_o, busy_o, dbg_ack_o, dbg_rdata_o, ready_o
    );

    modport slave (
        input  we0_i, waddr0_i, wdata0_i, we1_i, waddr1_i, wdata1_i, raddr_i,
        input  busy_set_i, busy_addr_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output rdata_o, busy_o, dbg_ack_o, dbg_rdata_o, ready_o
    );
endinterface

// File: rtl/cpu_regfile_mp.sv
// Integer register file: NRD combinational read ports, EX + LSU write ports (LSU wins),
// per-register busy scoreboard, post-reset clear sequencer and a debug access port.
module cpu_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    cpu_regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_RUN     = 2'd1,
        S_DBG_ACK = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [AW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_next;
    logic              r_ready;
    logic              r_dbg_ack;
    logic [XLEN-1:0]   r_dbg_rdata;
    logic              w_dbg_accept;
    logic              w_run;

    assign w_run = (r_state != S_CLEAR);

    // Debug accesses only slip in on cycles with no core writeback.
    always_comb begin
        w_state_next = r_state;
        w_dbg_accept = 1'b0;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == LAST_IDX) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (bus.dbg_req_i && !bus.we0_i && !bus.we1_i) begin
                    w_dbg_accept = 1'b1;
                    w_state_next = S_DBG_ACK;
                end
            end
            S_DBG_ACK: w_state_next = S_RUN;
            default:   w_state_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state     <= S_CLEAR;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ready   <= (w_state_next != S_CLEAR);
            r_dbg_ack <= w_dbg_accept;
            if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
            if (w_dbg_accept && !bus.dbg_we_i)
                r_dbg_rdata <= (bus.dbg_addr_i == '0) ? '0 : r_regs[bus.dbg_addr_i];
        end
    end

    // Storage is not reset; the clear sequencer zeroes it after every reset.
    always_ff @(posedge clk_in) begin
        if (rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                if (r_state == S_CLEAR) begin
                    if (r_cnt == AW'(i)) r_regs[i] <= '0;
                end else if (i != 0) begin
                    if (bus.we1_i && bus.waddr1_i == AW'(i))
                        r_regs[i] <= bus.wdata1_i;
                    else if (bus.we0_i && bus.waddr0_i == AW'(i))
                        r_regs[i] <= bus.wdata0_i;
                    else if (w_dbg_accept && bus.dbg_we_i && bus.dbg_addr_i == AW'(i))
                        r_regs[i] <= bus.dbg_wdata_i;
                end
            end
        end
    end

    assign w_busy_next[0] = 1'b0;

    genvar gi;
    // A newly issued producer takes precedence over a retiring one for the same register.
    for (gi = 1; gi < NREGS; gi++) begin : g_busy
        localparam logic [AW-1:0] IDX = AW'(gi);
        assign w_busy_next[gi] =
            (bus.busy_set_i && bus.busy_addr_i == IDX) ? 1'b1 :
            ((bus.we0_i && bus.waddr0_i == IDX) ||
             (bus.we1_i && bus.waddr1_i == IDX))    ? 1'b0 : r_busy[gi];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n)     r_busy <= '0;
        else if (w_run) r_busy <= w_busy_next;
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   w_raddr;
        logic [XLEN-1:0] w_rdata;

        assign w_raddr = bus.raddr_i[gi*AW +: AW];

        always_comb begin
            w_rdata = r_regs[w_raddr];
            if (!w_run || w_raddr == '0)
                w_rdata = '0;
            else if (BYPASS != 0 && bus.we1_i && bus.waddr1_i == w_raddr)
                w_rdata = bus.wdata1_i;
            else if (BYPASS != 0 && bus.we0_i && bus.waddr0_i == w_raddr)
                w_rdata = bus.wdata0_i;
        end

        assign bus.rdata_o[gi*XLEN +: XLEN] = w_rdata;
    end

    assign bus.busy_o      = r_busy;
    assign bus.ready_o     = r_ready;
    assign bus.dbg_ack_o   = r_dbg_ack;
    assign bus.dbg_rdata_o = r_dbg_rdata;
endmodule

// File: tb/tb_cpu_regfile_mp.sv
// Directed scoreboard bench for cpu_regfile_mp: a BYPASS=1 and a BYPASS=0 instance
// share one stimulus stream; expectations are queued at drive time and popped at sample time.
module tb_cpu_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    cpu_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) if_bp ();
    cpu_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) if_nb ();

    assign if_nb.we0_i       = if_bp.we0_i;
    assign if_nb.waddr0_i    = if_bp.waddr0_i;
    assign if_nb.wdata0_i    = if_bp.wdata0_i;
    assign if_nb.we1_i       = if_bp.we1_i;
    assign if_nb.waddr1_i    = if_bp.waddr1_i;
    assign if_nb.wdata1_i    = if_bp.wdata1_i;
    assign if_nb.raddr_i     = if_bp.raddr_i;
    assign if_nb.busy_set_i  = if_bp.busy_set_i;
    assign if_nb.busy_addr_i = if_bp.busy_addr_i;
    assign if_nb.dbg_req_i   = if_bp.dbg_req_i;
    assign if_nb.dbg_we_i    = if_bp.dbg_we_i;
    assign if_nb.dbg_addr_i  = if_bp.dbg_addr_i;
    assign if_nb.dbg_wdata_i = if_bp.dbg_wdata_i;

    cpu_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_dut_bp (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (if_bp.slave)
    );

    cpu_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_dut_nb (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (if_nb.slave)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            e = 'x;
            t = "empty_queue";
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
        end
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_raddr(input int k, input logic [AW-1:0] a);
        if_bp.raddr_i[k*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rd_bp(input int k);
        logic [NRD*XLEN-1:0] v;
        v = if_bp.rdata_o;
        return v[k*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] rd_nb(input int k);
        logic [NRD*XLEN-1:0] v;
        v = if_nb.rdata_o;
        return v[k*XLEN +: XLEN];
    endfunction

    initial begin
        int cycles;
        int early_ack;

        if_bp.we0_i = 0; if_bp.waddr0_i = '0; if_bp.wdata0_i = '0;
        if_bp.we1_i = 0; if_bp.waddr1_i = '0; if_bp.wdata1_i = '0;
        if_bp.raddr_i = '0;
        if_bp.busy_set_i = 0; if_bp.busy_addr_i = '0;
        if_bp.dbg_req_i = 0; if_bp.dbg_we_i = 0; if_bp.dbg_addr_i = '0; if_bp.dbg_wdata_i = '0;

        tick(); tick();
        expect_val("rst_busy", 32'h0);        check(if_bp.busy_o);
        expect_val("rst_ready", 32'h0);       check({31'b0, if_bp.ready_o});
        expect_val("rst_ack", 32'h0);         check({31'b0, if_bp.dbg_ack_o});
        expect_val("rst_dbg_rdata", 32'h0);   check(if_bp.dbg_rdata_o);

        // Release reset while hammering x5 during the clear sequence.
        rst_n = 1;
        if_bp.we0_i = 1; if_bp.waddr0_i = 5; if_bp.wdata0_i = 32'h12345678;
        set_raddr(0, 5);
        expect_val("clear_read_zero", 32'h0);
        #1 check(rd_bp(0));
        cycles = 0;
        while (!if_bp.ready_o && cycles < 40) begin
            tick();
            cycles++;
        end
        expect_val("clear_len", 32);          check(cycles);
        if_bp.we0_i = 0;
        expect_val("x5_after_clear_bp", 32'h0);
        expect_val("x5_after_clear_nb", 32'h0);
        #1 check(rd_bp(0));
        check(rd_nb(0));

        // Write/read same cycle: bypass vs. array-only.
        if_bp.we0_i = 1; if_bp.waddr0_i = 5; if_bp.wdata0_i = 32'hDEADBEEF;
        expect_val("bypass_same_cycle", 32'hDEADBEEF);
        expect_val("nobypass_same_cycle", 32'h0);
        #1 check(rd_bp(0));
        check(rd_nb(0));
        tick();
        if_bp.we0_i = 0;
        expect_val("bypass_next_cycle", 32'hDEADBEEF);
        expect_val("nobypass_next_cycle", 32'hDEADBEEF);
        #1 check(rd_bp(0));
        check(rd_nb(0));

        // Dual write to x7: LSU port wins, in both the bypass and the array.
        if_bp.we0_i = 1; if_bp.waddr0_i = 7; if_bp.wdata0_i = 32'h11111111;
        if_bp.we1_i = 1; if_bp.waddr1_i = 7; if_bp.wdata1_i = 32'h22222222;
        set_raddr(1, 7);
        expect_val("dual_write_bypass", 32'h22222222);
        #1 check(rd_bp(1));
        tick();
        if_bp.we0_i = 0; if_bp.we1_i = 0;
        expect_val("dual_write_array_nb", 32'h22222222);
        expect_val("dual_write_array_bp", 32'h22222222);
        #1 check(rd_nb(1));
        check(rd_bp(1));

        // x0 is hard-wired to zero.
        if_bp.we0_i = 1; if_bp.waddr0_i = 0; if_bp.wdata0_i = 32'hFFFFFFFF;
        set_raddr(0, 0);
        expect_val("x0_bypass", 32'h0);
        #1 check(rd_bp(0));
        tick();
        if_bp.we0_i = 0;
        expect_val("x0_array", 32'h0);
        #1 check(rd_nb(0));

        // Scoreboard.
        if_bp.busy_set_i = 1; if_bp.busy_addr_i = 3;
        expect_val("busy_set", 32'h8);
        tick(); check(if_bp.busy_o);
        if_bp.we0_i = 1; if_bp.waddr0_i = 3; if_bp.wdata0_i = 32'h33;
        expect_val("busy_set_wins", 32'h8);
        tick(); check(if_bp.busy_o);
        if_bp.busy_set_i = 0;
        expect_val("busy_clear", 32'h0);
        tick(); check(if_bp.busy_o);
        if_bp.we0_i = 0;
        if_bp.busy_set_i = 1; if_bp.busy_addr_i = 0;
        expect_val("busy_x0", 32'h0);
        tick(); check(if_bp.busy_o);
        if_bp.busy_set_i = 0;
        set_raddr(0, 3);
        expect_val("x3_value", 32'h33);
        #1 check(rd_nb(0));

        // Debug write stalled by EX writeback for three cycles.
        if_bp.dbg_req_i = 1; if_bp.dbg_we_i = 1; if_bp.dbg_addr_i = 10; if_bp.dbg_wdata_i = 32'hCAFEF00D;
        if_bp.we0_i = 1; if_bp.waddr0_i = 12; if_bp.wdata0_i = 32'h5;
        for (int i = 0; i < 3; i++) begin
            expect_val("dbg_stall_no_ack", 32'h0);
            tick(); check({31'b0, if_bp.dbg_ack_o});
        end
        if_bp.we0_i = 0;
        expect_val("dbg_write_ack", 32'h1);
        tick(); check({31'b0, if_bp.dbg_ack_o});
        if_bp.dbg_req_i = 0;
        expect_val("dbg_ack_one_cycle", 32'h0);
        tick(); check({31'b0, if_bp.dbg_ack_o});
        set_raddr(0, 10);
        expect_val("dbg_write_landed", 32'hCAFEF00D);
        #1 check(rd_nb(0));

        // Debug read; request held over the ack cycle must not re-accept immediately.
        if_bp.dbg_req_i = 1; if_bp.dbg_we_i = 0; if_bp.dbg_addr_i = 10;
        expect_val("dbg_read_ack", 32'h1);
        expect_val("dbg_read_data", 32'hCAFEF00D);
        tick(); check({31'b0, if_bp.dbg_ack_o});
        check(if_bp.dbg_rdata_o);
        expect_val("dbg_ackstate_no_accept", 32'h0);
        tick(); check({31'b0, if_bp.dbg_ack_o});
        if_bp.dbg_req_i = 0;
        expect_val("dbg_rdata_held", 32'hCAFEF00D);
        tick(); check(if_bp.dbg_rdata_o);

        // Reset while a debug write is stalled and x3 is busy.
        if_bp.busy_set_i = 1; if_bp.busy_addr_i = 3;
        expect_val("busy_before_reset", 32'h8);
        tick(); check(if_bp.busy_o);
        if_bp.busy_set_i = 0;
        if_bp.we0_i = 1; if_bp.waddr0_i = 12; if_bp.wdata0_i = 32'h6;
        if_bp.dbg_req_i = 1; if_bp.dbg_we_i = 1; if_bp.dbg_addr_i = 11; if_bp.dbg_wdata_i = 32'h0000ABCD;
        expect_val("stalled_no_ack", 32'h0);
        tick(); check({31'b0, if_bp.dbg_ack_o});
        rst_n = 0;
        expect_val("rst2_ack", 32'h0);
        expect_val("rst2_busy", 32'h0);
        expect_val("rst2_ready", 32'h0);
        tick();
        check({31'b0, if_bp.dbg_ack_o});
        check(if_bp.busy_o);
        check({31'b0, if_bp.ready_o});
        rst_n = 1;
        if_bp.we0_i = 0;
        cycles = 0;
        early_ack = 0;
        while (!if_bp.ready_o && cycles < 40) begin
            tick();
            cycles++;
            if (if_bp.dbg_ack_o) early_ack++;
        end
        expect_val("clear2_len", 32);         check(cycles);
        expect_val("no_ack_during_clear", 0); check(early_ack);
        expect_val("ack_after_ready", 32'h1);
        tick(); check({31'b0, if_bp.dbg_ack_o});
        if_bp.dbg_req_i = 0;
        set_raddr(0, 11);
        set_raddr(1, 12);
        expect_val("dbg_write_after_reset", 32'h0000ABCD);
        expect_val("x12_cleared", 32'h0);
        #1 check(rd_nb(0));
        check(rd_nb(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_regfile_mp.md
Name: cpu_regfile_mp

Overview:
Parametrised integer register file for the priRV32 core. It replaces the fixed 2-read/1-write file.
- Configurable data width, register count and number of read ports.
- Two write ports: EX writeback and late LSU writeback.
- Per-register busy scoreboard, a post-reset hardware clear sequencer, and a req/ack debug access port.
- Sits between ID (reads, busy checks) and EX/LSU (writeback).

Parameters:
XLEN, 32, data width in bits.
NREGS, 32, register count; power of two, 16 (RV32E) or 32. AW = clog2(NREGS), derived internally.
NRD, 2, number of combinational read ports (1..4).
BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return array contents only.

Ports:
clk_in  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, synchronous, active-low.
we0_i  in  1  EX write enable.
waddr0_i  in  AW  EX write address.
wdata0_i  in  XLEN  EX write data.
we1_i  in  1  LSU write enable.
waddr1_i  in  AW  LSU write address.
wdata1_i  in  XLEN  LSU write data.
raddr_i  in  NRD*AW  read addresses; port k at [k*AW +: AW].
rdata_o  out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN].
busy_set_i  in  1  ID issued an instruction writing busy_addr_i.
busy_addr_i  in  AW  destination register being marked busy.
busy_o  out  NREGS  registered scoreboard; bit r = register r has a pending write.
dbg_req_i  in  1  debug access request; held high until dbg_ack_o.
dbg_we_i  in  1  1 = debug write, 0 = debug read.
dbg_addr_i  in  AW  debug register address.
dbg_wdata_i  in  XLEN  debug write data.
dbg_ack_o  out  1  one-cycle acknowledge.
dbg_rdata_o  out  XLEN  debug read data; valid while dbg_ack_o is high and held afterwards.
ready_o  out  1  1 = clear sequence done, file operational.

Behaviour:
- FSM states: CLEAR, RUN, DBG_ACK.
- Reset (rst_n low at an edge):
  - State goes to CLEAR and the clear counter goes to 0.
  - Outputs: busy_o=0, ready_o=0, dbg_ack_o=0, dbg_rdata_o=0.
  - Reset can be applied in any state. It aborts a pending debug access (no ack is ever issued) and restarts the clear from 0.
- CLEAR:
  - Each edge with rst_n high writes 0 to regs[cnt] and increments cnt.
  - After the write to entry NREGS-1, state goes to RUN. ready_o is registered high in that same edge, i.e. NREGS edges after reset release.
  - In CLEAR, the write ports, busy_set_i and dbg_req_i are ignored, and all rdata_o read 0.
- Register writes (RUN and DBG_ACK):
  - we0_i and we1_i write at the edge.
  - Address 0 is never written and always reads 0.
  - If both ports target the same address, port 1 (LSU) wins.
- Reads: combinational, per port.
  - raddr=0 gives 0.
  - BYPASS=1: match on (we1_i, waddr1_i) gives wdata1_i; otherwise match on (we0_i, waddr0_i) gives wdata0_i; otherwise regs[raddr]. The priority matches the write priority.
  - BYPASS=0: regs[raddr] only; new data is visible the cycle after the write.
- Scoreboard, per register r != 0, at each edge in RUN/DBG_ACK:
  - Set if busy_set_i and busy_addr_i==r.
  - Clear if (we0_i and waddr0_i==r) or (we1_i and waddr1_i==r).
  - Set and clear in the same cycle: set wins (a new producer was issued).
  - busy_o[0] is constant 0. Debug writes do not affect busy.
- Debug handshake:
  - In RUN, dbg_req_i is accepted only in a cycle where we0_i=0 and we1_i=0; otherwise it stalls, with no bound.
  - On acceptance: a write updates regs[dbg_addr_i] (ignored if addr 0); a read captures regs[dbg_addr_i] (0 for addr 0, no bypass) into dbg_rdata_o.
  - After acceptance the state goes to DBG_ACK and dbg_ack_o=1 for exactly that cycle.
  - DBG_ACK returns to RUN on the next edge and accepts no new request. Minimum spacing between accepted requests is therefore 2 cycles.
  - The requester must drop or replace dbg_req_i after it sees the ack.
  - Core writes and scoreboard updates continue normally in DBG_ACK.

Test Plan:
1. NREGS=32: release rst_n, pulse we0_i x5=0x12345678 during CLEAR -> ready_o rises after exactly 32 edges; read x5 -> 0x00000000.
2. BYPASS=1: we0_i x5=0xDEADBEEF with raddr port0=5 in the same cycle -> rdata port0=0xDEADBEEF in that cycle and from the array the next cycle. BYPASS=0 instance -> old value 0x00000000 in the write cycle, 0xDEADBEEF the next cycle.
3. Same-cycle we0_i x7=0x11111111 and we1_i x7=0x22222222 -> read x7=0x22222222. Write x0=0xFFFFFFFF -> read x0=0.
4. busy_set x3 at edge N -> busy_o[3]=1 after N. Writeback x3 together with busy_set x3 -> stays 1. Writeback alone -> 0 next edge. busy_set x0 -> busy_o[0] stays 0.
5. Debug write x10=0xCAFEF00D with we0_i high for 3 cycles -> no ack during those cycles; ack 1 cycle after we0_i drops. Then debug read x10 -> dbg_ack_o=1 with dbg_rdata_o=0xCAFEF00D.
6. rst_n low for 1 cycle while a debug request is stalled and busy_o=0x00000008 -> no ack, busy_o=0, ready_o=0. Clear reruns a full 32 cycles; the request is accepted only after ready_o=1.
